// File: rtl/eth_rx_ram_arbiter.sv
// eth_rx_ram_arbiter
// Controller for the received-packet dual-port RAM. One RAM port is shared
// between the ingress writer (requester 0) and the ecpri_rx reader
// (requester 1) using round-robin arbitration with a burst limit. The block
// also holds a small FIFO of completed-packet lengths and drives the
// recv_pkt/pkt_ack handshake towards ecpri_rx.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   req_0/gnt_0/addr_0/wdata_0/we_0   writer request, grant and command
//   req_1/gnt_1/addr_1/rdata_1/rvalid_1  reader request, grant and read data
//   ram_cs/ram_we/ram_oe/ram_addr/ram_wdata/ram_rdata  RAM command bus
//   pkt_done/pkt_len_in   writer pushes a completed frame length
//   recv_pkt/pkt_len_out  descriptor available / head length
//   pkt_ack               reader pops the head descriptor
//   desc_ovf              sticky: descriptor dropped on a full FIFO
//
// Optional feature (macro ARB_STATS_EN): adds saturating 16-bit counters
//   stat_gnt0_cnt, stat_gnt1_cnt, stat_conflict_cnt.
module eth_rx_ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_BURST  = 16,
  parameter int DESC_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_0,
  output logic                  gnt_0,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  input  logic                  we_0,
  input  logic                  req_1,
  output logic                  gnt_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  rvalid_1,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  pkt_done,
  input  logic [15:0]           pkt_len_in,
  output logic                  recv_pkt,
  output logic [15:0]           pkt_len_out,
  input  logic                  pkt_ack,
`ifdef ARB_STATS_EN
  output logic [15:0]           stat_gnt0_cnt,
  output logic [15:0]           stat_gnt1_cnt,
  output logic [15:0]           stat_conflict_cnt,
`endif
  output logic                  desc_ovf
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int PW = $clog2(DESC_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;        // 0 favours writer, 1 favours reader
  logic [BW-1:0]   burst_q, burst_d;
  logic            gnt0_q, gnt1_q;
  logic            burst_at_max;

  // The counter saturates so a long solo burst still yields promptly once
  // the other requester shows up.
  assign burst_at_max = (burst_q == BURST_LAST);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (req_0 && req_1) state_d = rr_q ? OWN1 : OWN0;
        else if (req_0)     state_d = OWN0;
        else if (req_1)     state_d = OWN1;
      end
      OWN0: begin
        if (!req_0)                    state_d = req_1 ? OWN1 : IDLE;
        else if (burst_at_max && req_1) state_d = OWN1;
      end
      OWN1: begin
        if (!req_1)                    state_d = req_0 ? OWN0 : IDLE;
        else if (burst_at_max && req_0) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
    if (state_q == OWN0 && state_d != OWN0) rr_d = 1'b1;
    if (state_q == OWN1 && state_d != OWN1) rr_d = 1'b0;
    if (state_d != state_q)                    burst_d = '0;
    else if (state_q != IDLE && !burst_at_max) burst_d = burst_q + 1'b1;
  end

  // Grants are registered from the next state, so they rise one cycle
  // after the arbitration decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      burst_q <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      gnt0_q  <= (state_d == OWN0);
      gnt1_q  <= (state_d == OWN1);
    end
  end

  assign gnt_0 = gnt0_q;
  assign gnt_1 = gnt1_q;

  // RAM command register and read-valid pipeline
  logic                  acc0, acc1;
  logic                  ram_cs_q, ram_we_q, ram_oe_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic                  rd_vld_p1_q, rd_vld_p2_q;

  assign acc0 = gnt0_q & req_0;
  assign acc1 = gnt1_q & req_1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_vld_p1_q <= 1'b0;
      rd_vld_p2_q <= 1'b0;
    end else begin
      ram_cs_q    <= acc0 | acc1;
      ram_we_q    <= acc0 & we_0;
      ram_oe_q    <= acc1;
      rd_vld_p1_q <= acc1;
      rd_vld_p2_q <= rd_vld_p1_q;
      if (acc0) begin
        ram_addr_q  <= addr_0;
        ram_wdata_q <= wdata_0;
      end else if (acc1) begin
        ram_addr_q  <= addr_1;
      end
    end
  end

  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_oe    = ram_oe_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rdata_1   = ram_rdata;
  assign rvalid_1  = rd_vld_p2_q;

  // Descriptor FIFO
  logic [15:0]   desc_mem [DESC_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DESC_DEPTH));
  assign pop   = pkt_ack & ~empty;
  // A push into a full FIFO still succeeds when the head leaves this cycle.
  assign push  = pkt_done & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) desc_mem[wptr_q] <= pkt_len_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
      if (pkt_done && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign recv_pkt    = ~empty;
  assign pkt_len_out = empty ? 16'h0000 : desc_mem[rptr_q];
  assign desc_ovf    = ovf_q;

`ifdef ARB_STATS_EN
  logic [15:0] st_g0_q, st_g1_q, st_cf_q;
  logic        conflict;

  assign conflict = (gnt0_q & req_1) | (gnt1_q & req_0);

  always_ff @(posedge clk) begin
    if (reset) begin
      st_g0_q <= '0;
      st_g1_q <= '0;
      st_cf_q <= '0;
    end else begin
      if (gnt0_q && st_g0_q != 16'hFFFF)   st_g0_q <= st_g0_q + 1'b1;
      if (gnt1_q && st_g1_q != 16'hFFFF)   st_g1_q <= st_g1_q + 1'b1;
      if (conflict && st_cf_q != 16'hFFFF) st_cf_q <= st_cf_q + 1'b1;
    end
  end

  assign stat_gnt0_cnt     = st_g0_q;
  assign stat_gnt1_cnt     = st_g1_q;
  assign stat_conflict_cnt = st_cf_q;
`endif

endmodule

// File: tb/tb_eth_rx_ram_arbiter.sv
// Testbench for eth_rx_ram_arbiter: directed scenarios followed by random
// traffic, all checked each cycle against a behavioural reference model
// (grant owner, flat reference memory, descriptor queue).
module tb_eth_rx_ram_arbiter;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 16;
  localparam int MAX_BURST  = 16;
  localparam int DESC_DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        req_0, we_0, req_1;
  logic        gnt_0, gnt_1;
  logic [15:0] addr_0, addr_1;
  logic [7:0]  wdata_0, rdata_1;
  logic        rvalid_1;
  logic        ram_cs, ram_we, ram_oe;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        pkt_done, pkt_ack, recv_pkt, desc_ovf;
  logic [15:0] pkt_len_in, pkt_len_out;
`ifdef ARB_STATS_EN
  logic [15:0] stat_gnt0_cnt, stat_gnt1_cnt, stat_conflict_cnt;
`endif

  eth_rx_ram_arbiter #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .MAX_BURST(MAX_BURST), .DESC_DEPTH(DESC_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .gnt_0(gnt_0), .addr_0(addr_0), .wdata_0(wdata_0), .we_0(we_0),
    .req_1(req_1), .gnt_1(gnt_1), .addr_1(addr_1), .rdata_1(rdata_1), .rvalid_1(rvalid_1),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pkt_done(pkt_done), .pkt_len_in(pkt_len_in), .recv_pkt(recv_pkt),
    .pkt_len_out(pkt_len_out), .pkt_ack(pkt_ack),
`ifdef ARB_STATS_EN
    .stat_gnt0_cnt(stat_gnt0_cnt), .stat_gnt1_cnt(stat_gnt1_cnt),
    .stat_conflict_cnt(stat_conflict_cnt),
`endif
    .desc_ovf(desc_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM standing in for ram_dp_sr_sw
  logic [7:0] ram_mem [65536];
  logic [7:0] ram_rd_q;
  assign ram_rdata = ram_rd_q;
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      if (ram_oe) ram_rd_q <= ram_mem[ram_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int we_pulses = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int         m_owner = -1;   // -1 nobody, 0 writer, 1 reader
  int         m_held  = 0;    // consecutive cycles of the current owner
  int         m_rr    = 0;
  logic       m_g0 = 0, m_g1 = 0, m_cs = 0, m_we = 0, m_oe = 0;
  logic [15:0] m_addr = 0;
  logic [7:0]  m_wdata = 0;
  logic       rv1 = 0, rv2 = 0, k1 = 0, k2 = 0;
  logic [7:0] d1 = 0, d2 = 0;
  logic [7:0] refmem [65536];
  bit         refwr  [65536];
  int         dq[$];
  logic       m_ovf = 0;

  task automatic model_step();
    logic acc0, acc1, mine, other, pop, full;
    int nxt, tmp;
    if (reset) begin
      m_owner = -1; m_held = 0; m_rr = 0;
      m_g0 = 0; m_g1 = 0; m_cs = 0; m_we = 0; m_oe = 0;
      m_addr = 0; m_wdata = 0;
      rv1 = 0; rv2 = 0; k1 = 0; k2 = 0;
      dq.delete(); m_ovf = 0;
    end else begin
      acc0 = m_g0 && req_0;
      acc1 = m_g1 && req_1;
      rv2 = rv1; d2 = d1; k2 = k1;
      rv1 = acc1;
      if (acc1) begin d1 = refmem[addr_1]; k1 = refwr[addr_1]; end
      if (acc0 && we_0) begin refmem[addr_0] = wdata_0; refwr[addr_0] = 1'b1; end
      m_cs = acc0 || acc1;
      m_we = acc0 && we_0;
      m_oe = acc1;
      if (acc0) begin m_addr = addr_0; m_wdata = wdata_0; end
      else if (acc1) m_addr = addr_1;
      // arbitration
      if (m_owner < 0) begin
        if (req_0 && req_1) nxt = m_rr;
        else if (req_0)     nxt = 0;
        else if (req_1)     nxt = 1;
        else                nxt = -1;
      end else begin
        mine  = (m_owner == 0) ? req_0 : req_1;
        other = (m_owner == 0) ? req_1 : req_0;
        if (!mine)                                nxt = other ? 1 - m_owner : -1;
        else if (other && m_held >= MAX_BURST-1)  nxt = 1 - m_owner;
        else                                      nxt = m_owner;
      end
      if (nxt != m_owner) begin
        if (m_owner >= 0) m_rr = 1 - m_owner;
        m_held = 0;
      end else if (m_owner >= 0 && m_held < MAX_BURST-1) begin
        m_held++;
      end
      m_owner = nxt;
      m_g0 = (nxt == 0);
      m_g1 = (nxt == 1);
      // descriptor queue
      full = (dq.size() == DESC_DEPTH);
      pop  = pkt_ack && (dq.size() > 0);
      if (pop) tmp = dq.pop_front();
      if (pkt_done) begin
        if (!full || pop) dq.push_back(int'(pkt_len_in));
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare();
    check_eq("gnt_0", 32'(gnt_0), 32'(m_g0));
    check_eq("gnt_1", 32'(gnt_1), 32'(m_g1));
    check_eq("gnt_excl", 32'(gnt_0 & gnt_1), 32'(0));
    check_eq("ram_cs", 32'(ram_cs), 32'(m_cs));
    check_eq("ram_we", 32'(ram_we), 32'(m_we));
    check_eq("ram_oe", 32'(ram_oe), 32'(m_oe));
    if (m_cs) check_eq("ram_addr", 32'(ram_addr), 32'(m_addr));
    if (m_we) check_eq("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
    check_eq("rvalid_1", 32'(rvalid_1), 32'(rv2));
    if (rv2 && k2) check_eq("rdata_1", 32'(rdata_1), 32'(d2));
    check_eq("recv_pkt", 32'(recv_pkt), 32'(dq.size() > 0));
    check_eq("pkt_len_out", 32'(pkt_len_out), (dq.size() > 0) ? 32'(dq[0]) : 32'(0));
    check_eq("desc_ovf", 32'(desc_ovf), 32'(m_ovf));
    if (ram_we) we_pulses++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic push_len(input logic [15:0] len);
    pkt_done = 1'b1; pkt_len_in = len;
    cycle();
    pkt_done = 1'b0;
  endtask

  task automatic ack_once();
    pkt_ack = 1'b1;
    cycle();
    pkt_ack = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  int k;
  logic acc;
  int c_g0a, c_g1a, c_g0b, c_g1b, c_ovl;
  logic [15:0] exp_len [4];
  int pr0, pr1;

  initial begin
    reset = 1'b1; req_0 = 0; we_0 = 0; req_1 = 0;
    addr_0 = 0; addr_1 = 0; wdata_0 = 0;
    pkt_done = 0; pkt_ack = 0; pkt_len_in = 0;
    for (int i = 0; i < 65536; i++) begin refmem[i] = 8'h00; refwr[i] = 1'b0; end

    cycle();
    cycle();
    check_eq("rst_ram_addr", 32'(ram_addr), 32'(0));
    check_eq("rst_ram_wdata", 32'(ram_wdata), 32'(0));
    check_eq("rst_pkt_len_out", 32'(pkt_len_out), 32'(0));
    reset = 1'b0;
    cycle();

    // Writer alone: 0xA0..0xA4 into 0x0036..0x003A
    we_pulses = 0;
    req_0 = 1; we_0 = 1; addr_0 = 16'h0036; wdata_0 = 8'hA0; k = 0;
    check_eq("wr_gnt_pre", 32'(gnt_0), 32'(0));
    cycle();
    check_eq("wr_gnt_rise", 32'(gnt_0), 32'(1));
    for (int g = 0; g < 40 && k < 5; g++) begin
      acc = gnt_0;
      cycle();
      if (acc) begin
        k++;
        addr_0 = 16'h0036 + 16'(k);
        wdata_0 = 8'hA0 + 8'(k);
      end
    end
    req_0 = 0; we_0 = 0;
    check_eq("wr_done", 32'(k), 32'(5));
    cycle();
    cycle();
    check_eq("wr_we_pulses", 32'(we_pulses), 32'(5));

    // Reader reads back 0x0038
    req_1 = 1; addr_1 = 16'h0038; acc = 0;
    for (int g = 0; g < 20 && !acc; g++) begin
      acc = gnt_1;
      cycle();
    end
    req_1 = 0;
    check_eq("rd_accepted", 32'(acc), 32'(1));
    check_eq("rd_lat_n1", 32'(rvalid_1), 32'(0));
    cycle();
    check_eq("rd_lat_n2", 32'(rvalid_1), 32'(1));
    check_eq("rd_data_a2", 32'(rdata_1), 32'(8'hA2));
    cycle();
    cycle();

    // Contention from IDLE with pointer favouring the writer
    pulse_reset();
    req_0 = 1; req_1 = 1; we_0 = 0; addr_0 = 16'h0010; addr_1 = 16'h0011;
    c_g0a = 0; c_g1a = 0; c_g0b = 0; c_g1b = 0; c_ovl = 0;
    for (int c = 0; c < 64; c++) begin
      cycle();
      if (gnt_0 && gnt_1) c_ovl++;
      if (c < 16 && gnt_0) c_g0a++;
      if (c >= 16 && c < 32 && gnt_1) c_g1a++;
      if (c >= 32 && c < 48 && gnt_0) c_g0b++;
      if (c >= 48 && gnt_1) c_g1b++;
    end
    check_eq("cont_g0_first", 32'(c_g0a), 32'(16));
    check_eq("cont_g1_second", 32'(c_g1a), 32'(16));
    check_eq("cont_g0_third", 32'(c_g0b), 32'(16));
    check_eq("cont_g1_fourth", 32'(c_g1b), 32'(16));
    check_eq("cont_overlap", 32'(c_ovl), 32'(0));
`ifdef ARB_STATS_EN
    check_eq("stat_g0", 32'(stat_gnt0_cnt >= 16'd31 && stat_gnt0_cnt <= 16'd33), 32'(1));
    check_eq("stat_g1", 32'(stat_gnt1_cnt >= 16'd31 && stat_gnt1_cnt <= 16'd33), 32'(1));
    check_eq("stat_conflict", 32'(stat_conflict_cnt >= 16'd62), 32'(1));
`endif
    req_0 = 0; req_1 = 0;
    cycle();
    cycle();

    // Descriptor flow
    push_len(16'd60); push_len(16'd64); push_len(16'd1500);
    check_eq("desc_recv", 32'(recv_pkt), 32'(1));
    check_eq("desc_head60", 32'(pkt_len_out), 32'(60));
    exp_len[0] = 16'd60; exp_len[1] = 16'd64; exp_len[2] = 16'd1500;
    for (int i = 0; i < 3; i++) begin
      check_eq("desc_order", 32'(pkt_len_out), 32'(exp_len[i]));
      ack_once();
    end
    check_eq("desc_empty", 32'(recv_pkt), 32'(0));
    ack_once();   // ack on empty queue is ignored
    check_eq("desc_empty_ack", 32'(recv_pkt), 32'(0));

    // Overflow: fifth push dropped
    for (int i = 0; i < 5; i++) push_len(16'd100 + 16'(i));
    check_eq("ovf_set", 32'(desc_ovf), 32'(1));
    check_eq("ovf_head", 32'(pkt_len_out), 32'(100));

    // Full queue with simultaneous push and ack: nothing dropped
    pulse_reset();
    check_eq("ovf_cleared", 32'(desc_ovf), 32'(0));
    for (int i = 0; i < 4; i++) push_len(16'd100 + 16'(i));
    pkt_ack = 1'b1;
    push_len(16'd200);
    pkt_ack = 1'b0;
    check_eq("pp_full_no_ovf", 32'(desc_ovf), 32'(0));
    check_eq("pp_full_head", 32'(pkt_len_out), 32'(101));
    exp_len[0] = 16'd101; exp_len[1] = 16'd102; exp_len[2] = 16'd103; exp_len[3] = 16'd200;
    for (int i = 0; i < 4; i++) begin
      check_eq("pp_order", 32'(pkt_len_out), 32'(exp_len[i]));
      ack_once();
    end
    check_eq("pp_empty", 32'(recv_pkt), 32'(0));
    // Push and ack together on an empty queue: push only
    pkt_ack = 1'b1;
    push_len(16'd333);
    pkt_ack = 1'b0;
    check_eq("pp_empty_push", 32'(pkt_len_out), 32'(333));
    ack_once();

    // Reset during a reader burst with a read in flight
    push_len(16'd77);
    req_1 = 1; addr_1 = 16'h0038; acc = 0;
    for (int g = 0; g < 20 && !acc; g++) begin
      acc = gnt_1;
      cycle();
    end
    check_eq("rst_rd_accepted", 32'(acc), 32'(1));
    check_eq("rst_pre_recv", 32'(recv_pkt), 32'(1));
    req_1 = 0;
    pulse_reset();
    check_eq("rst_gnt_1", 32'(gnt_1), 32'(0));
    check_eq("rst_rvalid_1", 32'(rvalid_1), 32'(0));
    check_eq("rst_recv_pkt", 32'(recv_pkt), 32'(0));
    check_eq("rst_ram_cs", 32'(ram_cs), 32'(0));

    // Random traffic
    pr0 = 50; pr1 = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        pr0 = $urandom_range(10, 95);
        pr1 = $urandom_range(10, 95);
      end
      reset      = ($urandom_range(0, 299) == 0);
      req_0      = ($urandom_range(0, 99) < pr0);
      req_1      = ($urandom_range(0, 99) < pr1);
      we_0       = ($urandom_range(0, 3) != 0);
      addr_0     = 16'($urandom_range(0, 31));
      addr_1     = 16'($urandom_range(0, 31));
      wdata_0    = 8'($urandom);
      pkt_done   = ($urandom_range(0, 2) == 0);
      pkt_ack    = ($urandom_range(0, 3) == 0);
      pkt_len_in = 16'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
